// File: rtl/rv32i_mmio_bridge_pkg.sv
// Shared types and MMIO register map for the rv32i memory/MMIO bridge.
// Offsets are byte offsets within the 256-byte MMIO window.
package mmio_pkg;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

    localparam logic [7:0] MMIO_LEDS      = 8'h00;
    localparam logic [7:0] MMIO_BUTTONS   = 8'h04;
    localparam logic [7:0] MMIO_CYCLE_LO  = 8'h08;
    localparam logic [7:0] MMIO_CYCLE_HI  = 8'h0C;
    localparam logic [7:0] MMIO_INSTRET   = 8'h10;
    localparam logic [7:0] MMIO_TIMER_CMP = 8'h14;
    localparam logic [7:0] MMIO_STATUS    = 8'h18;

    localparam int unsigned STATUS_TIMER_BIT = 0;

endpackage

// File: rtl/rv32i_mmio_bridge_if.sv
// Word-wide memory bus: the core drives it as master, the bridge forwards
// it to RAM as master again.
interface rv32i_mmio_bridge_if;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    logic [31:0] rd_data;

    modport master (output addr, output wr_data, output wr_ena, input rd_data);
    modport slave  (input addr, input wr_data, input wr_ena, output rd_data);
endinterface

// File: rtl/rv32i_mmio_bridge_counter64.sv
// 64-bit counter; a read of the low word snapshots the high word so a
// following CYCLE_HI read is coherent with the low word already returned.
module mmio_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        lo_rd,
    output logic [31:0] count_lo,
    output logic [31:0] hi_latch
);

    logic [63:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            hi_latch <= '0;
        end else begin
            if (inc)   count    <= count + 64'd1;
            if (lo_rd) hi_latch <= count[63:32];
        end
    end

    assign count_lo = count[31:0];

endmodule

// File: rtl/rv32i_mmio_bridge_reg.sv
// Plain D register with synchronous active-low reset; two in series form
// the button synchroniser.
module mmio_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

endmodule

// File: rtl/rv32i_mmio_bridge.sv
// Splits core accesses between block RAM and a small MMIO register bank,
// 1-cycle read latency for both. Optional macro: RV32I_MMIO_INSTRET_EN.
import mmio_pkg::*;

module rv32i_mmio_bridge #(
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
    parameter int unsigned N_LEDS    = 8,
    parameter int unsigned N_BUTTONS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32i_mmio_bridge_if.slave       core,
    rv32i_mmio_bridge_if.master      ram,
    input  logic                     instructions_completed,
    output logic [N_LEDS-1:0]        leds,
    input  logic [N_BUTTONS-1:0]     buttons,
    output logic                     timer_irq,
    output logic                     bus_error
);

    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic           aligned;
    logic           ram_hit;
    logic           mmio_hit;
    region_t        region;
    region_t        region_q;
    logic [7:0]     offset;
    logic           mmio_we;
    logic           lo_rd;
    logic [31:0]    mmio_rd_val;
    logic [31:0]    mmio_rd_q;
    logic [31:0]    timer_cmp;
    logic [31:0]    cycle_lo;
    logic [31:0]    cycle_hi_latch;
    logic [31:0]    instret;
    logic [N_BUTTONS-1:0] btn_meta;
    logic [N_BUTTONS-1:0] btn_sync;

    assign aligned  = (core.addr[1:0] == 2'b00);
    assign ram_hit  = (core.addr < RAM_BYTES);
    assign mmio_hit = (core.addr[31:8] == MMIO_BASE[31:8]);
    assign offset   = core.addr[7:0];

    always_comb begin
        region = REGION_NONE;
        if (aligned && ram_hit)       region = REGION_RAM;
        else if (aligned && mmio_hit) region = REGION_MMIO;
    end

    // Gating with rst keeps a store issued during reset from reaching RAM.
    assign ram.addr    = {2'b00, core.addr[31:2]};
    assign ram.wr_data = core.wr_data;
    assign ram.wr_ena  = core.wr_ena && rst && (region == REGION_RAM);

    assign mmio_we = core.wr_ena && (region == REGION_MMIO);
    assign lo_rd   = (region == REGION_MMIO) && (offset == MMIO_CYCLE_LO);

    mmio_reg #(.WIDTH(N_BUTTONS)) u_btn_meta (
        .clk (clk), .rst (rst), .d (buttons), .q (btn_meta)
    );

    mmio_reg #(.WIDTH(N_BUTTONS)) u_btn_sync (
        .clk (clk), .rst (rst), .d (btn_meta), .q (btn_sync)
    );

    mmio_counter64 u_cycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .lo_rd    (lo_rd),
        .count_lo (cycle_lo),
        .hi_latch (cycle_hi_latch)
    );

`ifdef RV32I_MMIO_INSTRET_EN
    always_ff @(posedge clk) begin
        if (!rst)                        instret <= '0;
        else if (instructions_completed) instret <= instret + 32'd1;
    end
`else
    logic unused_instructions_completed;
    assign unused_instructions_completed = instructions_completed;
    assign instret = '0;
`endif

    always_comb begin
        mmio_rd_val = '0;
        case (offset)
            MMIO_LEDS:      mmio_rd_val = 32'(leds);
            MMIO_BUTTONS:   mmio_rd_val = 32'(btn_sync);
            MMIO_CYCLE_LO:  mmio_rd_val = cycle_lo;
            MMIO_CYCLE_HI:  mmio_rd_val = cycle_hi_latch;
            MMIO_INSTRET:   mmio_rd_val = instret;
            MMIO_TIMER_CMP: mmio_rd_val = timer_cmp;
            MMIO_STATUS:    mmio_rd_val[STATUS_TIMER_BIT] = timer_irq;
            default:        mmio_rd_val = '0;
        endcase
    end

    // Read value is captured from pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            leds      <= '0;
            timer_cmp <= '1;
            timer_irq <= 1'b0;
            bus_error <= 1'b0;
            region_q  <= REGION_NONE;
            mmio_rd_q <= '0;
        end else begin
            region_q  <= region;
            mmio_rd_q <= mmio_rd_val;
            if (region == REGION_NONE) bus_error <= 1'b1;
            if (mmio_we && offset == MMIO_LEDS)      leds      <= core.wr_data[N_LEDS-1:0];
            if (mmio_we && offset == MMIO_TIMER_CMP) timer_cmp <= core.wr_data;
            if (cycle_lo == timer_cmp)
                timer_irq <= 1'b1;
            else if (mmio_we && offset == MMIO_STATUS && core.wr_data[STATUS_TIMER_BIT])
                timer_irq <= 1'b0;
        end
    end

    always_comb begin
        case (region_q)
            REGION_RAM:  core.rd_data = ram.rd_data;
            REGION_MMIO: core.rd_data = mmio_rd_q;
            default:     core.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mmio_bridge.sv
// Directed self-checking bench for rv32i_mmio_bridge with a synchronous RAM model.
module tb_rv32i_mmio_bridge;

    localparam logic [31:0] BASE = 32'hF000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_done = 1'b0;
    logic [3:0] buttons = 4'h0;
    logic [7:0] leds;
    logic       timer_irq;
    logic       bus_error;

    int compared   = 0;
    int mismatched = 0;
    int unsigned cyc_model = 0;
    logic [31:0] mem [256];

    rv32i_mmio_bridge_if core_bus();
    rv32i_mmio_bridge_if ram_bus();

    rv32i_mmio_bridge #(
        .RAM_WORDS (256),
        .MMIO_BASE (BASE),
        .N_LEDS    (8),
        .N_BUTTONS (4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .core                   (core_bus),
        .ram                    (ram_bus),
        .instructions_completed (instr_done),
        .leds                   (leds),
        .buttons                (buttons),
        .timer_irq              (timer_irq),
        .bus_error              (bus_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_bus.wr_ena) mem[ram_bus.addr[7:0]] <= ram_bus.wr_data;
        ram_bus.rd_data <= mem[ram_bus.addr[7:0]];
    end

    always @(posedge clk) begin
        if (!rst) cyc_model <= 0;
        else      cyc_model <= cyc_model + 1;
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        core_bus.addr    = a;
        core_bus.wr_data = d;
        core_bus.wr_ena  = w;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        compared++; if (leds !== 8'h00) begin mismatched++; $display("FAIL reset_leds got %h want 00", leds); end
        compared++; if (timer_irq !== 1'b0) begin mismatched++; $display("FAIL reset_irq got %b want 0", timer_irq); end
        compared++; if (bus_error !== 1'b0) begin mismatched++; $display("FAIL reset_berr got %b want 0", bus_error); end
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_rd got %h want 0", core_bus.rd_data); end
        rst = 1'b1;
        drive(BASE + 32'h08, 32'h0, 1'b0);
        @(negedge clk);
        drive(BASE + 32'h0C, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL reset_cycle_hi got %h want 0", core_bus.rd_data); end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_ram();
        drive(32'h0, 32'h1111_1111, 1'b1);
        @(negedge clk);
        drive(32'h10, 32'hDEAD_BEEF, 1'b1);
        #1;
        compared++; if (ram_bus.wr_ena !== 1'b1) begin mismatched++; $display("FAIL ram_we got %b want 1", ram_bus.wr_ena); end
        compared++; if (ram_bus.addr !== 32'h4) begin mismatched++; $display("FAIL ram_addr got %h want 4", ram_bus.addr); end
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL ram_same_cycle_old got %h want 0", core_bus.rd_data); end
        drive(32'h10, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL ram_read got %h want deadbeef", core_bus.rd_data); end
        drive(32'h3FC, 32'hCAFE_F00D, 1'b1);
        #1;
        compared++; if (ram_bus.wr_ena !== 1'b1 || ram_bus.addr !== 32'hFF) begin mismatched++; $display("FAIL ram_top_word got we=%b addr=%h want 1/ff", ram_bus.wr_ena, ram_bus.addr); end
        @(negedge clk);
        drive(32'h3FC, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL ram_top_read got %h want cafef00d", core_bus.rd_data); end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_leds();
        drive(BASE, 32'h1A5, 1'b1);
        @(negedge clk);
        compared++; if (leds !== 8'hA5) begin mismatched++; $display("FAIL leds_write got %h want a5", leds); end
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL leds_old_read got %h want 0", core_bus.rd_data); end
        drive(BASE, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'hA5) begin mismatched++; $display("FAIL leds_read got %h want a5", core_bus.rd_data); end
        drive(BASE + 32'h08, 32'hFF, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        compared++; if (leds !== 8'hA5) begin mismatched++; $display("FAIL leds_ro_write got %h want a5", leds); end
        compared++; if (bus_error !== 1'b0) begin mismatched++; $display("FAIL ro_write_berr got %b want 0", bus_error); end
    endtask

    task automatic test_errors();
        drive(32'h8000_0000, 32'h1234, 1'b1);
        #1;
        compared++; if (ram_bus.wr_ena !== 1'b0) begin mismatched++; $display("FAIL unmapped_we got %b want 0", ram_bus.wr_ena); end
        @(negedge clk);
        compared++; if (bus_error !== 1'b1) begin mismatched++; $display("FAIL unmapped_berr got %b want 1", bus_error); end
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL unmapped_rd got %h want 0", core_bus.rd_data); end
        drive(32'h2, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL misaligned_rd got %h want 0", core_bus.rd_data); end
        drive(32'h400, 32'h5, 1'b1);
        #1;
        compared++; if (ram_bus.wr_ena !== 1'b0) begin mismatched++; $display("FAIL ram_limit_we got %b want 0", ram_bus.wr_ena); end
        @(negedge clk);
        drive(BASE + 32'h01, 32'hFF, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        compared++; if (leds !== 8'hA5) begin mismatched++; $display("FAIL misaligned_mmio_write got %h want a5", leds); end
        repeat (3) @(negedge clk);
        compared++; if (bus_error !== 1'b1) begin mismatched++; $display("FAIL berr_sticky got %b want 1", bus_error); end
    endtask

    task automatic test_timer();
        int unsigned cmp_t;
        bit reached;
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (bus_error !== 1'b0 || leds !== 8'h00) begin mismatched++; $display("FAIL timer_reset got berr=%b leds=%h want 0/00", bus_error, leds); end
        rst = 1'b1;
        drive(BASE + 32'h14, 32'd20, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        repeat (19) @(negedge clk);
        compared++; if (timer_irq !== 1'b0) begin mismatched++; $display("FAIL timer_early got %b want 0", timer_irq); end
        @(negedge clk);
        compared++; if (timer_irq !== 1'b1) begin mismatched++; $display("FAIL timer_hit got %b want 1", timer_irq); end
        drive(BASE + 32'h08, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'd21) begin mismatched++; $display("FAIL cycle_lo got %0d want 21", core_bus.rd_data); end
        drive(32'h0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        compared++; if (timer_irq !== 1'b1) begin mismatched++; $display("FAIL timer_sticky got %b want 1", timer_irq); end
        drive(BASE + 32'h18, 32'h1, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        compared++; if (timer_irq !== 1'b0) begin mismatched++; $display("FAIL timer_clear got %b want 0", timer_irq); end
        cmp_t = cyc_model + 3;
        drive(BASE + 32'h14, cmp_t, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cyc_model == cmp_t) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        compared++; if (!reached) begin mismatched++; $display("FAIL timer_wait got timeout want cycle %0d", cmp_t); end
        drive(BASE + 32'h18, 32'h1, 1'b1);
        @(negedge clk);
        drive(32'h0, 32'h0, 1'b0);
        compared++; if (timer_irq !== 1'b1) begin mismatched++; $display("FAIL timer_set_wins got %b want 1", timer_irq); end
    endtask

    task automatic test_reset_midaccess();
        drive(BASE + 32'h14, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h20, 32'h77, 1'b1);
        #1;
        compared++; if (ram_bus.wr_ena !== 1'b0) begin mismatched++; $display("FAIL midreset_we got %b want 0", ram_bus.wr_ena); end
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL midreset_rd got %h want 0", core_bus.rd_data); end
        compared++; if (timer_irq !== 1'b0) begin mismatched++; $display("FAIL midreset_irq got %b want 0", timer_irq); end
        drive(32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_inputs();
        logic [31:0] exp_instret;
`ifdef RV32I_MMIO_INSTRET_EN
        exp_instret = 32'd7;
`else
        exp_instret = 32'd0;
`endif
        buttons = 4'hA;
        for (int i = 0; i < 7; i++) begin
            instr_done = 1'b1;
            @(negedge clk);
            instr_done = 1'b0;
            @(negedge clk);
        end
        drive(BASE + 32'h04, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'hA) begin mismatched++; $display("FAIL buttons got %h want a", core_bus.rd_data); end
        drive(BASE + 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== exp_instret) begin mismatched++; $display("FAIL instret got %0d want %0d", core_bus.rd_data, exp_instret); end
        drive(BASE + 32'h1C, 32'h0, 1'b0);
        @(negedge clk);
        compared++; if (core_bus.rd_data !== 32'h0) begin mismatched++; $display("FAIL unused_offset got %h want 0", core_bus.rd_data); end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        drive(32'h0, 32'h0, 1'b0);
        test_reset();
        test_ram();
        test_leds();
        test_errors();
        test_timer();
        test_reset_midaccess();
        test_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
